// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader.
//   loader_state_e : loader FSM states
//   NOP_INSTR      : word returned for fetches outside the instruction RAM
//   ERR_*          : err_code values
//   state_accepts(): states in which a stream byte may be accepted
// Optional feature macro: LOADER_CHECKSUM_EN (see program_loader.sv).
package loader_pkg;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CSUM,
        S_DONE,
        S_ERROR
    } loader_state_e;

    localparam logic [15:0] NOP_INSTR = 16'hC000;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;

    // Terminal states refuse bytes until load_start or reset.
    function automatic logic state_accepts(loader_state_e st);
        return (st == S_LEN_HI) || (st == S_LEN_LO) || (st == S_DATA_HI) ||
               (st == S_DATA_LO) || (st == S_CSUM);
    endfunction

endpackage

// File: rtl/instr_ram.sv
// Instruction store: MEM_SIZE x 16-bit words, synchronous write, asynchronous read.
// No reset: contents survive rst and reloads until overwritten.
// Ports:
//   clk   : write clock
//   we    : write enable
//   waddr : write index
//   wdata : write word
//   raddr : read index
//   rdata : read word (combinational)
module instr_ram #(
    parameter int MEM_SIZE = 64,
    parameter int ADDR_W   = $clog2(MEM_SIZE)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [15:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [15:0]       rdata
);

    logic [15:0] mem_q [MEM_SIZE];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader. Receives a byte stream (16-bit length, then that many
// big-endian 16-bit words, then optionally an XOR checksum byte), writes the words
// into instr_ram and releases the CPU reset once a load completes without error.
// Afterwards it serves combinational instruction fetches.
//
// Build option: define LOADER_CHECKSUM_EN to accumulate an XOR over every length and
// data byte and require a trailing checksum byte. Without it the load ends after the
// last data byte (or straight after the length when it is zero).
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   in_data        : stream byte
//   in_valid       : in_data valid
//   in_ready       : loader can take a byte (transfer on in_valid & in_ready)
//   load_start     : one-cycle pulse restarting the load
//   address        : CPU fetch address
//   instruction    : fetched word (NOP_INSTR beyond the RAM)
//   cpu_rst        : CPU reset, high until a load succeeds
//   load_done      : last load succeeded
//   load_error     : last load failed
//   err_code       : ERR_NONE / ERR_LEN / ERR_CSUM
//   words_loaded   : words written by the current or last load
module program_loader
    import loader_pkg::*;
#(
    parameter int MEM_SIZE = 64,
    parameter int ADDR_W   = $clog2(MEM_SIZE)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        load_start,
    input  logic [15:0] address,
    output logic [15:0] instruction,
    output logic        cpu_rst,
    output logic        load_done,
    output logic        load_error,
    output logic [1:0]  err_code,
    output logic [15:0] words_loaded
);

    loader_state_e state_q;
    logic [15:0]   len_q;
    logic [7:0]    data_hi_q;
    logic [15:0]   words_q;
    logic          cpu_rst_q;
    logic          done_q;
    logic          error_q;
    logic [1:0]    err_code_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    csum_q;
`endif

    logic          accept;
    logic [15:0]   len_d;
    logic          len_over;
    logic [15:0]   words_d;
    logic          ram_we;
    logic [15:0]   ram_rdata;
    logic          addr_in_range;

    // A restart or reset owns the cycle, so no byte can slip in alongside it.
    always_comb begin
        in_ready = 1'b0;
        if (!rst && !load_start) begin
            in_ready = state_accepts(state_q);
        end
    end

    assign accept   = in_valid && in_ready;
    assign len_d    = {len_q[15:8], in_data};
    assign len_over = {1'b0, len_d} > 17'(MEM_SIZE);
    assign words_d  = words_q + 16'd1;
    assign ram_we   = accept && (state_q == S_DATA_LO);

    always_ff @(posedge clk) begin
        if (rst || load_start) begin
            state_q    <= S_LEN_HI;
            len_q      <= '0;
            data_hi_q  <= '0;
            words_q    <= '0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else if (accept) begin
`ifdef LOADER_CHECKSUM_EN
            if (state_q != S_CSUM) begin
                csum_q <= csum_q ^ in_data;
            end
`endif
            unique case (state_q)
                S_LEN_HI: begin
                    len_q[15:8] <= in_data;
                    state_q     <= S_LEN_LO;
                end
                S_LEN_LO: begin
                    len_q <= len_d;
                    if (len_over) begin
                        state_q    <= S_ERROR;
                        error_q    <= 1'b1;
                        err_code_q <= ERR_LEN;
                    end else if (len_d == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_q   <= S_CSUM;
`else
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        cpu_rst_q <= 1'b0;
`endif
                    end else begin
                        state_q <= S_DATA_HI;
                    end
                end
                S_DATA_HI: begin
                    data_hi_q <= in_data;
                    state_q   <= S_DATA_LO;
                end
                S_DATA_LO: begin
                    words_q <= words_d;
                    if (words_d < len_q) begin
                        state_q <= S_DATA_HI;
                    end else begin
`ifdef LOADER_CHECKSUM_EN
                        state_q   <= S_CSUM;
`else
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        cpu_rst_q <= 1'b0;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (in_data == csum_q) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        cpu_rst_q <= 1'b0;
                    end else begin
                        state_q    <= S_ERROR;
                        error_q    <= 1'b1;
                        err_code_q <= ERR_CSUM;
                    end
                end
`endif
                default: ; // terminal states never accept a byte
            endcase
        end
    end

    instr_ram #(
        .MEM_SIZE(MEM_SIZE),
        .ADDR_W  (ADDR_W)
    ) u_instr_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(words_q[ADDR_W-1:0]),
        .wdata({data_hi_q, in_data}),
        .raddr(address[ADDR_W-1:0]),
        .rdata(ram_rdata)
    );

    assign addr_in_range = {1'b0, address} < 17'(MEM_SIZE);
    assign instruction   = addr_in_range ? ram_rdata : NOP_INSTR;

    assign cpu_rst      = cpu_rst_q;
    assign load_done    = done_q;
    assign load_error   = error_q;
    assign err_code     = err_code_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: drives byte streams, keeps a model of the instruction RAM
// and a queue of expected (address, word) pairs that are read back through the fetch
// port once each load has finished. Works with and without LOADER_CHECKSUM_EN.
module tb_program_loader;

    localparam int MEM_SIZE = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        load_start;
    logic [15:0] address;
    logic [15:0] instruction;
    logic        cpu_rst;
    logic        load_done;
    logic        load_error;
    logic [1:0]  err_code;
    logic [15:0] words_loaded;

    always #5 clk = ~clk;

    program_loader #(
        .MEM_SIZE(MEM_SIZE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .load_start  (load_start),
        .address     (address),
        .instruction (instruction),
        .cpu_rst     (cpu_rst),
        .load_done   (load_done),
        .load_error  (load_error),
        .err_code    (err_code),
        .words_loaded(words_loaded)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] stim_q[$];
    logic [15:0] model_mem [MEM_SIZE];
    bit          known [MEM_SIZE];
    int          total = 0;
    int          bad = 0;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_flip = 8'h00;
`endif

    // {cpu_rst, load_done, load_error, err_code, words_loaded, in_ready}
    function automatic logic [21:0] flags();
        return {cpu_rst, load_done, load_error, err_code, words_loaded, in_ready};
    endfunction

    function automatic logic [21:0] want(input bit c, input bit d, input bit e,
                                         input logic [1:0] code, input logic [15:0] wl,
                                         input bit rdy);
        return {c, d, e, code, wl, rdy};
    endfunction

    // Offer one byte from a negedge; returns after the posedge that takes it.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int budget;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                in_valid = 1'b0;
                #1;
                total++;
                if (cpu_rst !== 1'b1) begin
                    bad++;
                    $display("FAIL gap_cpu_rst got=%b want=1", cpu_rst);
                end
            end
        end
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        #1;
        budget = 0;
        while (in_ready !== 1'b1 && budget < 16) begin
            @(negedge clk);
            #1;
            budget++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL byte_ready got=%b want=1 byte=%h", in_ready, b);
        end
        @(posedge clk);
    endtask

    task automatic load_stream(input logic [15:0] n, input bit gaps);
        logic [15:0] w;
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] cs;
        cs = n[15:8] ^ n[7:0];
`endif
        send_byte(n[15:8], gaps);
        send_byte(n[7:0], gaps);
        for (int i = 0; i < stim_q.size(); i++) begin
            w = stim_q[i];
            send_byte(w[15:8], gaps);
            send_byte(w[7:0], gaps);
            exp_q.push_back({16'(i), w});
            model_mem[i] = w;
            known[i]     = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            cs = cs ^ w[15:8] ^ w[7:0];
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        if ({1'b0, n} <= 17'(MEM_SIZE)) begin
            send_byte(cs ^ csum_flip, gaps);
        end
`endif
        @(negedge clk);
        in_valid = 1'b0;
        #1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        load_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load_start = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        load_start = 1'b0;
        address    = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready got=%b want=0", in_ready);
        end
        rst = 1'b0;
        #1;
        total++;
        if (flags() !== want(1, 0, 0, 2'b00, 16'd0, 1)) begin
            bad++;
            $display("FAIL reset_flags got=%h want=%h", flags(), want(1, 0, 0, 2'b00, 16'd0, 1));
        end
    endtask

    task automatic test_basic_load();
        exp_t e;
        stim_q = '{16'h4005, 16'h6007};
        load_stream(16'd2, 1'b0);
        total++;
        if (flags() !== want(0, 1, 0, 2'b00, 16'd2, 0)) begin
            bad++;
            $display("FAIL basic_flags got=%h want=%h", flags(), want(0, 1, 0, 2'b00, 16'd2, 0));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            address = e.addr;
            #1;
            total++;
            if (instruction !== e.data) begin
                bad++;
                $display("FAIL basic_mem[%0d] got=%h want=%h", e.addr, instruction, e.data);
            end
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_bad_checksum();
        exp_t e;
        pulse_start();
        stim_q    = '{16'h4005, 16'h6007};
        csum_flip = 8'h03;
        load_stream(16'd2, 1'b0);
        csum_flip = 8'h00;
        total++;
        if (flags() !== want(1, 0, 1, 2'b10, 16'd2, 0)) begin
            bad++;
            $display("FAIL csum_flags got=%h want=%h", flags(), want(1, 0, 1, 2'b10, 16'd2, 0));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            address = e.addr;
            #1;
            total++;
            if (instruction !== e.data) begin
                bad++;
                $display("FAIL csum_mem[%0d] got=%h want=%h", e.addr, instruction, e.data);
            end
        end
    endtask
`endif

    task automatic test_length_bounds();
        exp_t e;
        pulse_start();
        stim_q.delete();
        load_stream(16'h0041, 1'b0);
        total++;
        if (flags() !== want(1, 0, 1, 2'b01, 16'd0, 0)) begin
            bad++;
            $display("FAIL over_flags got=%h want=%h", flags(), want(1, 0, 1, 2'b01, 16'd0, 0));
        end
        for (int i = 0; i < MEM_SIZE; i++) begin
            if (known[i]) begin
                @(negedge clk);
                address = 16'(i);
                #1;
                total++;
                if (instruction !== model_mem[i]) begin
                    bad++;
                    $display("FAIL over_nowrite[%0d] got=%h want=%h", i, instruction,
                             model_mem[i]);
                end
            end
        end
        pulse_start();
        stim_q.delete();
        for (int i = 0; i < MEM_SIZE; i++) stim_q.push_back(16'($urandom));
        load_stream(16'(MEM_SIZE), 1'b0);
        total++;
        if (flags() !== want(0, 1, 0, 2'b00, 16'(MEM_SIZE), 0)) begin
            bad++;
            $display("FAIL full_flags got=%h want=%h", flags(),
                     want(0, 1, 0, 2'b00, 16'(MEM_SIZE), 0));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            address = e.addr;
            #1;
            total++;
            if (instruction !== e.data) begin
                bad++;
                $display("FAIL full_mem[%0d] got=%h want=%h", e.addr, instruction, e.data);
            end
        end
    endtask

    task automatic test_gapped_load();
        exp_t e;
        for (int pass = 0; pass < 2; pass++) begin
            pulse_start();
            stim_q = '{16'h1234, 16'hBEEF, 16'h0F0F};
            load_stream(16'd3, pass == 1);
            total++;
            if (flags() !== want(0, 1, 0, 2'b00, 16'd3, 0)) begin
                bad++;
                $display("FAIL gap%0d_flags got=%h want=%h", pass, flags(),
                         want(0, 1, 0, 2'b00, 16'd3, 0));
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                @(negedge clk);
                address = e.addr;
                #1;
                total++;
                if (instruction !== e.data) begin
                    bad++;
                    $display("FAIL gap%0d_mem[%0d] got=%h want=%h", pass, e.addr, instruction,
                             e.data);
                end
            end
        end
    endtask

    // Restart with a byte on the bus: 0x7F must be dropped, otherwise it would become
    // the length high byte and the following 1-word load would overflow.
    task automatic test_restart();
        exp_t e;
        @(negedge clk);
        load_start = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'h7F;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL restart_ready got=%b want=0", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        load_start = 1'b0;
        in_valid   = 1'b0;
        #1;
        total++;
        if (flags() !== want(1, 0, 0, 2'b00, 16'd0, 1)) begin
            bad++;
            $display("FAIL restart_flags got=%h want=%h", flags(), want(1, 0, 0, 2'b00, 16'd0, 1));
        end
        stim_q = '{16'hABCD};
        load_stream(16'd1, 1'b0);
        total++;
        if (flags() !== want(0, 1, 0, 2'b00, 16'd1, 0)) begin
            bad++;
            $display("FAIL reload_flags got=%h want=%h", flags(), want(0, 1, 0, 2'b00, 16'd1, 0));
        end
        exp_q.delete();
        for (int i = 0; i < MEM_SIZE; i++) begin
            if (known[i]) exp_q.push_back({16'(i), model_mem[i]});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            address = e.addr;
            #1;
            total++;
            if (instruction !== e.data) begin
                bad++;
                $display("FAIL reload_mem[%0d] got=%h want=%h", e.addr, instruction, e.data);
            end
        end
    endtask

    task automatic test_read_range_and_empty();
        logic [15:0] addrs [3];
        logic [15:0] wants [3];
        addrs = '{16'h0040, 16'hFFFF, 16'h003F};
        wants = '{16'hC000, 16'hC000, model_mem[63]};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            address = addrs[i];
            #1;
            total++;
            if (instruction !== wants[i]) begin
                bad++;
                $display("FAIL read_%h got=%h want=%h", addrs[i], instruction, wants[i]);
            end
        end
        pulse_start();
        stim_q.delete();
        load_stream(16'd0, 1'b0);
        total++;
        if (flags() !== want(0, 1, 0, 2'b00, 16'd0, 0)) begin
            bad++;
            $display("FAIL empty_flags got=%h want=%h", flags(), want(0, 1, 0, 2'b00, 16'd0, 0));
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
`ifdef LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_length_bounds();
        test_gapped_load();
        test_restart();
        test_read_range_and_empty();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
